// File: rtl/dac_gearbox_pkg.sv
// Shared types and helpers for the DAC sample gearbox.
// Ring pointer arithmetic lives here so the storage and any future users wrap the same way.
package dac_gearbox_pkg;

  typedef enum logic [0:0] {StFill, StRun} gb_state_e;

  localparam int unsigned UnderrunCntW = 16;

  // Operands are assumed < depth, so a single conditional subtract replaces a modulo.
  function automatic int unsigned ptr_wrap(input int unsigned ptr, input int unsigned inc,
                                           input int unsigned depth);
    int unsigned sum;
    sum = ptr + inc;
    if (sum >= depth) sum = sum - depth;
    return sum;
  endfunction

endpackage

// File: rtl/dac_sample_ring.sv
// Ring buffer that writes IN_LANES samples and reads OUT_LANES samples per cycle.
// Read data is combinational from the read pointer; fill counts samples held.
module dac_sample_ring
  import dac_gearbox_pkg::*;
#(
  parameter int unsigned SAMPLE_W    = 14,
  parameter int unsigned IN_LANES    = 5,
  parameter int unsigned OUT_LANES   = 2,
  parameter int unsigned BUF_SAMPLES = 16,
  localparam int unsigned PtrW       = (BUF_SAMPLES > 1) ? $clog2(BUF_SAMPLES) : 1,
  localparam int unsigned FillW      = $clog2(BUF_SAMPLES + 1)
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           wr_en_i,
  input  logic [IN_LANES*SAMPLE_W-1:0]   wr_data_i,
  input  logic                           rd_en_i,
  output logic [OUT_LANES*SAMPLE_W-1:0]  rd_data_o,
  output logic [FillW-1:0]               fill_o
);

  logic [SAMPLE_W-1:0] mem_q [BUF_SAMPLES];
  logic [PtrW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [FillW-1:0]    fill_q, fill_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_en_i) wr_ptr_d = PtrW'(ptr_wrap(32'(wr_ptr_q), IN_LANES, BUF_SAMPLES));
    if (rd_en_i) rd_ptr_d = PtrW'(ptr_wrap(32'(rd_ptr_q), OUT_LANES, BUF_SAMPLES));
    fill_d = fill_q + (wr_en_i ? FillW'(IN_LANES) : FillW'(0))
                    - (rd_en_i ? FillW'(OUT_LANES) : FillW'(0));
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      fill_q   <= fill_d;
    end
  end

  // Storage is not reset: contents are only ever read behind the fill count.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      for (int unsigned i = 0; i < IN_LANES; i++) begin
        mem_q[PtrW'(ptr_wrap(32'(wr_ptr_q), i, BUF_SAMPLES))] <=
            wr_data_i[i*SAMPLE_W +: SAMPLE_W];
      end
    end
  end

  always_comb begin
    rd_data_o = '0;
    for (int unsigned j = 0; j < OUT_LANES; j++) begin
      rd_data_o[j*SAMPLE_W +: SAMPLE_W] = mem_q[PtrW'(ptr_wrap(32'(rd_ptr_q), j, BUF_SAMPLES))];
    end
  end

  assign fill_o = fill_q;

endmodule

// File: rtl/dac_sample_gearbox.sv
// IN_LANES-to-OUT_LANES sample gearbox with prefill/underrun FSM and registered output beat.
// Define DAC_GEARBOX_TESTPAT_EN to add the test_mode input and the internal ramp source.
module dac_sample_gearbox
  import dac_gearbox_pkg::*;
#(
  parameter int unsigned SAMPLE_W    = 14,
  parameter int unsigned IN_LANES    = 5,
  parameter int unsigned OUT_LANES   = 2,
  parameter int unsigned BUF_SAMPLES = 16,
  parameter int unsigned START_LEVEL = 8
) (
  input  logic                                sysclk_in,
  input  logic                                sys_reset,
  input  logic [IN_LANES*SAMPLE_W-1:0]        in_data,
  input  logic                                in_valid,
  output logic                                in_ready,
  output logic [OUT_LANES*SAMPLE_W-1:0]       out_data,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [UnderrunCntW-1:0]             underrun_cnt,
  output logic [$clog2(BUF_SAMPLES+1)-1:0]    fill_level
`ifdef DAC_GEARBOX_TESTPAT_EN
  ,
  input  logic                                test_mode
`endif
);

  localparam int unsigned FillW = $clog2(BUF_SAMPLES + 1);

  if (BUF_SAMPLES < IN_LANES + OUT_LANES) begin : gen_buf_chk
    $error("BUF_SAMPLES must be >= IN_LANES + OUT_LANES");
  end
  if (START_LEVEL < OUT_LANES || START_LEVEL > BUF_SAMPLES) begin : gen_start_chk
    $error("START_LEVEL must lie in OUT_LANES..BUF_SAMPLES");
  end

  gb_state_e                     state_q, state_d;
  logic                          out_valid_q, out_valid_d;
  logic [OUT_LANES*SAMPLE_W-1:0] out_data_q, out_data_d;
  logic [UnderrunCntW-1:0]       underrun_cnt_q, underrun_cnt_d;
  logic [FillW-1:0]              fill;
  logic [OUT_LANES*SAMPLE_W-1:0] rd_data;
  logic                          wr_valid;
  logic [IN_LANES*SAMPLE_W-1:0]  wr_data;
  logic                          acc;
  logic                          load;

`ifdef DAC_GEARBOX_TESTPAT_EN
  logic                test_mode_q;
  logic [SAMPLE_W-1:0] ramp_base_q, ramp_base_d, ramp_start;

  // A fresh entry into test mode restarts the ramp at zero on that same beat.
  assign ramp_start = (test_mode && !test_mode_q) ? '0 : ramp_base_q;
  assign wr_valid   = test_mode ? 1'b1 : in_valid;

  always_comb begin
    wr_data = in_data;
    if (test_mode) begin
      for (int unsigned i = 0; i < IN_LANES; i++) begin
        wr_data[i*SAMPLE_W +: SAMPLE_W] = ramp_start + SAMPLE_W'(i);
      end
    end
  end

  always_comb begin
    ramp_base_d = ramp_start;
    if (test_mode && acc) ramp_base_d = ramp_start + SAMPLE_W'(IN_LANES);
  end

  always_ff @(posedge sysclk_in or posedge sys_reset) begin
    if (sys_reset) begin
      test_mode_q <= 1'b0;
      ramp_base_q <= '0;
    end else begin
      test_mode_q <= test_mode;
      ramp_base_q <= ramp_base_d;
    end
  end
`else
  assign wr_valid = in_valid;
  assign wr_data  = in_data;
`endif

  assign in_ready = !sys_reset && (fill <= FillW'(BUF_SAMPLES - IN_LANES));
  assign acc      = wr_valid && in_ready;
  assign load     = (state_q == StRun) && (!out_valid_q || out_ready) &&
                    (fill >= FillW'(OUT_LANES));

  dac_sample_ring #(
    .SAMPLE_W    (SAMPLE_W),
    .IN_LANES    (IN_LANES),
    .OUT_LANES   (OUT_LANES),
    .BUF_SAMPLES (BUF_SAMPLES)
  ) u_ring (
    .clk_i     (sysclk_in),
    .rst_i     (sys_reset),
    .wr_en_i   (acc),
    .wr_data_i (wr_data),
    .rd_en_i   (load),
    .rd_data_o (rd_data),
    .fill_o    (fill)
  );

  always_comb begin
    state_d        = state_q;
    out_valid_d    = out_valid_q;
    out_data_d     = out_data_q;
    underrun_cnt_d = underrun_cnt_q;
    unique case (state_q)
      StFill: begin
        if (out_valid_q && out_ready) out_valid_d = 1'b0;
        if (fill >= FillW'(START_LEVEL)) state_d = StRun;
      end
      StRun: begin
        if (load) begin
          out_valid_d = 1'b1;
          out_data_d  = rd_data;
        end else if (out_valid_q && out_ready) begin
          // Beat consumed with nothing to replace it: underrun.
          out_valid_d = 1'b0;
          state_d     = StFill;
          if (underrun_cnt_q != '1) underrun_cnt_d = underrun_cnt_q + UnderrunCntW'(1);
        end
      end
      default: state_d = StFill;
    endcase
  end

  always_ff @(posedge sysclk_in or posedge sys_reset) begin
    if (sys_reset) begin
      state_q        <= StFill;
      out_valid_q    <= 1'b0;
      out_data_q     <= '0;
      underrun_cnt_q <= '0;
    end else begin
      state_q        <= state_d;
      out_valid_q    <= out_valid_d;
      out_data_q     <= out_data_d;
      underrun_cnt_q <= underrun_cnt_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign out_data     = out_data_q;
  assign underrun_cnt = underrun_cnt_q;
  assign fill_level   = fill;

endmodule

// File: tb/tb_dac_sample_gearbox.sv
// Randomized self-checking bench for dac_sample_gearbox: sample-queue scoreboard plus scenarios.
// Builds with or without DAC_GEARBOX_TESTPAT_EN; the ramp scenario only exists with it.
module tb_dac_sample_gearbox;

  localparam int unsigned SW  = 14;
  localparam int unsigned IL  = 5;
  localparam int unsigned OL  = 2;
  localparam int unsigned BUF = 16;
  localparam int unsigned FW  = $clog2(BUF + 1);
  localparam int unsigned PL  = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [IL*SW-1:0] in_data;
  logic             in_valid, in_ready;
  logic [OL*SW-1:0] out_data;
  logic             out_valid, out_ready;
  logic [15:0]      underrun_cnt;
  logic [FW-1:0]    fill_level;
`ifdef DAC_GEARBOX_TESTPAT_EN
  logic             test_mode;
`endif

  logic [PL*SW-1:0] pt_in_data, pt_out_data;
  logic             pt_in_valid, pt_in_ready, pt_out_valid, pt_out_ready;
  logic [15:0]      pt_underrun_cnt;
  logic [FW-1:0]    pt_fill_level;

  dac_sample_gearbox #(
    .SAMPLE_W(SW), .IN_LANES(IL), .OUT_LANES(OL), .BUF_SAMPLES(BUF), .START_LEVEL(8)
  ) u_dut (
    .sysclk_in    (clk),
    .sys_reset    (rst),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .underrun_cnt (underrun_cnt),
    .fill_level   (fill_level)
`ifdef DAC_GEARBOX_TESTPAT_EN
    ,
    .test_mode    (test_mode)
`endif
  );

  dac_sample_gearbox #(
    .SAMPLE_W(SW), .IN_LANES(PL), .OUT_LANES(PL), .BUF_SAMPLES(BUF), .START_LEVEL(PL)
  ) u_pt (
    .sysclk_in    (clk),
    .sys_reset    (rst),
    .in_data      (pt_in_data),
    .in_valid     (pt_in_valid),
    .in_ready     (pt_in_ready),
    .out_data     (pt_out_data),
    .out_valid    (pt_out_valid),
    .out_ready    (pt_out_ready),
    .underrun_cnt (pt_underrun_cnt),
    .fill_level   (pt_fill_level)
`ifdef DAC_GEARBOX_TESTPAT_EN
    ,
    .test_mode    (1'b0)
`endif
  );

  int checks   = 0;
  int failures = 0;

  // Scoreboard: every sample accepted goes into exp_q, every sample emitted into got_q.
  int          exp_q[$];
  int          got_q[$];
  int          acc_samp, cons_samp, viol;
  logic        hold_prev;
  logic [OL*SW-1:0] hold_data;

  int src_val, acc_beats, beat_limit;
  bit ramp_src;

  task automatic mon_clear();
    exp_q.delete();
    got_q.delete();
    acc_samp  = 0;
    cons_samp = 0;
    hold_prev = 1'b0;
  endtask

  task automatic mon_sample(output bit acc);
    bit tm;
    int exp_fill;
    tm = 1'b0;
`ifdef DAC_GEARBOX_TESTPAT_EN
    tm = test_mode;
`endif
    exp_fill = acc_samp - cons_samp - (out_valid ? int'(OL) : 0);
    if (int'(fill_level) != exp_fill) viol++;
    if (in_ready !== (int'(fill_level) <= int'(BUF - IL))) viol++;
    if (hold_prev && (!out_valid || out_data !== hold_data)) viol++;
    acc = (in_valid || tm) && in_ready;
    if (acc) begin
      if (!tm) for (int i = 0; i < int'(IL); i++) exp_q.push_back(int'(in_data[i*SW +: SW]));
      acc_samp += IL;
    end
    if (out_valid && out_ready) begin
      for (int i = 0; i < int'(OL); i++) got_q.push_back(int'(out_data[i*SW +: SW]));
      cons_samp += OL;
    end
    hold_prev = out_valid && !out_ready;
    hold_data = out_data;
  endtask

  task automatic next_beat();
    for (int i = 0; i < int'(IL); i++) begin
      in_data[i*SW +: SW] = ramp_src ? SW'(src_val + i) : SW'($urandom);
    end
    src_val += IL;
  endtask

  task automatic drive_cycle(input int vpct, input int rpct);
    bit acc;
    @(negedge clk);
    mon_sample(acc);
    @(posedge clk);
    #1;
    if (acc) begin
      acc_beats++;
      next_beat();
    end
    in_valid  = (acc_beats < beat_limit) && (int'($urandom_range(99)) < vpct);
    out_ready = int'($urandom_range(99)) < rpct;
  endtask

  task automatic release_reset(input int start);
    repeat (2) @(posedge clk);
    src_val   = start;
    acc_beats = 0;
    next_beat();
    @(negedge clk);
    rst = 1'b0;
    mon_clear();
  endtask

  task automatic apply_reset(input int start, input bit ramp);
    rst         = 1'b1;
    in_valid    = 1'b0;
    out_ready   = 1'b0;
    pt_in_valid = 1'b0;
`ifdef DAC_GEARBOX_TESTPAT_EN
    test_mode   = 1'b0;
`endif
    ramp_src    = ramp;
    beat_limit  = 1 << 30;
    viol        = 0;
    mon_clear();
    release_reset(start);
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b0) begin failures++;
      $display("FAIL reset_in_ready got %0b want 0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++;
      $display("FAIL reset_out_valid got %0b want 0", out_valid); end
    checks++; if (out_data !== '0) begin failures++;
      $display("FAIL reset_out_data got %0h want 0", out_data); end
    checks++; if (fill_level !== '0) begin failures++;
      $display("FAIL reset_fill got %0d want 0", fill_level); end
    checks++; if (underrun_cnt !== 16'd0) begin failures++;
      $display("FAIL reset_underrun got %0d want 0", underrun_cnt); end
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++;
      $display("FAIL release_in_ready got %0b want 1", in_ready); end
    repeat (4) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0 || fill_level !== '0) begin failures++;
      $display("FAIL idle_after_reset got valid=%0b fill=%0d want 0/0", out_valid, fill_level); end
  endtask

  task automatic check_ramp(input string name, input int base);
    int bad;
    bad = -1;
    foreach (got_q[i]) if (bad < 0 && got_q[i] != ((base + i) % (1 << SW))) bad = i;
    checks++;
    if (bad != -1) begin
      failures++;
      $display("FAIL %s sample %0d got %0d want %0d", name, bad, got_q[bad],
               (base + bad) % (1 << SW));
    end
  endtask

  task automatic test_stream();
    int first, gaps, rdy;
    apply_reset(0, 1'b1);
    first = -1; gaps = 0; rdy = 0;
    for (int c = 0; c < 120; c++) begin
      drive_cycle(100, 100);
      if (out_valid && first < 0) first = c;
      if (first >= 0 && !out_valid) gaps++;
      if (c >= 60 && c < 110 && in_ready) rdy++;
    end
    checks++; if (first < 0 || first > 8) begin failures++;
      $display("FAIL stream_start got cycle %0d want 0..8", first); end
    checks++; if (gaps != 0) begin failures++;
      $display("FAIL stream_gaps got %0d want 0", gaps); end
    checks++; if (rdy != 20) begin failures++;
      $display("FAIL stream_in_ready_duty got %0d/50 want 20/50", rdy); end
    checks++; if (got_q.size() < 150) begin failures++;
      $display("FAIL stream_count got %0d want >=150", got_q.size()); end
    check_ramp("stream_order", 0);
    checks++; if (underrun_cnt !== 16'd0) begin failures++;
      $display("FAIL stream_underrun got %0d want 0", underrun_cnt); end
  endtask

  task automatic test_backpressure();
    for (int c = 0; c < 12; c++) drive_cycle(100, 0);
    checks++; if (in_ready !== 1'b0 || int'(fill_level) <= int'(BUF - IL)) begin failures++;
      $display("FAIL bp_full got in_ready=%0b fill=%0d want 0/>11", in_ready, fill_level); end
    checks++; if (out_valid !== 1'b1) begin failures++;
      $display("FAIL bp_valid_held got %0b want 1", out_valid); end
    for (int c = 0; c < 40; c++) drive_cycle(100, 100);
    check_ramp("bp_resume_order", 0);
    checks++; if (viol != 0 || underrun_cnt !== 16'd0) begin failures++;
      $display("FAIL bp_invariants got viol=%0d underrun=%0d want 0/0", viol, underrun_cnt); end
  endtask

  task automatic test_underrun();
    apply_reset(0, 1'b1);
    beat_limit = 8;
    for (int c = 0; c < 60; c++) drive_cycle(100, 100);
    checks++; if (got_q.size() != 40 || got_q[got_q.size()-1] != 39) begin failures++;
      $display("FAIL ur_drain got count=%0d want 40 ending at 39", got_q.size()); end
    checks++; if (out_valid !== 1'b0) begin failures++;
      $display("FAIL ur_out_valid got %0b want 0", out_valid); end
    checks++; if (underrun_cnt !== 16'd1) begin failures++;
      $display("FAIL ur_count got %0d want 1", underrun_cnt); end
    beat_limit = 1 << 30;
    for (int c = 0; c < 40; c++) drive_cycle(100, 100);
    checks++; if (got_q.size() < 42 || got_q[40] != 40 || got_q[41] != 41) begin failures++;
      $display("FAIL ur_restart got count=%0d want (40,41) at index 40", got_q.size()); end
    check_ramp("ur_order", 0);
    checks++; if (underrun_cnt !== 16'd1 || viol != 0) begin failures++;
      $display("FAIL ur_after got underrun=%0d viol=%0d want 1/0", underrun_cnt, viol); end
  endtask

  task automatic test_reset_mid();
    bit found;
    apply_reset(0, 1'b1);
    found = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      drive_cycle(100, 100);
      if (fill_level == FW'(10) && out_valid) found = 1'b1;
    end
    checks++; if (!found) begin failures++;
      $display("FAIL rm_reach_fill10 got no cycle with fill=10 and valid within 40 cycles"); end
    rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0 || fill_level !== '0 || in_ready !== 1'b0) begin failures++;
      $display("FAIL rm_immediate got valid=%0b fill=%0d ready=%0b want 0/0/0",
               out_valid, fill_level, in_ready); end
    in_valid = 1'b0;
    release_reset(1000);
    for (int c = 0; c < 30; c++) drive_cycle(100, 100);
    checks++; if (got_q.size() == 0 || got_q[0] != 1000) begin failures++;
      $display("FAIL rm_first_sample got %0d want 1000", got_q.size() ? got_q[0] : -1); end
    check_ramp("rm_order", 1000);
  endtask

  task automatic test_random();
    int bad;
    apply_reset(0, 1'b0);
    for (int c = 0; c < 400; c++) drive_cycle(70, 60);
    for (int c = 0; c < 40; c++) drive_cycle(0, 100);
    bad = -1;
    foreach (got_q[i]) if (bad < 0 && got_q[i] != exp_q[i]) bad = i;
    checks++; if (got_q.size() < 200 || got_q.size() > exp_q.size()) begin failures++;
      $display("FAIL rnd_count got %0d want 200..%0d", got_q.size(), exp_q.size()); end
    checks++; if (bad != -1) begin failures++;
      $display("FAIL rnd_order index %0d got %0d want %0d", bad, got_q[bad], exp_q[bad]); end
    checks++; if (viol != 0) begin failures++;
      $display("FAIL rnd_invariants got %0d violations want 0", viol); end
  endtask

  task automatic test_passthrough();
    logic [PL*SW-1:0] beats[$];
    int acc_cyc[$];
    int nout;
    apply_reset(0, 1'b1);
    pt_out_ready = 1'b1;
    for (int i = 0; i < int'(PL); i++) pt_in_data[i*SW +: SW] = SW'($urandom);
    nout = 0;
    for (int n = 0; n < 40; n++) begin
      bit acc;
      @(negedge clk);
      if (pt_out_valid && pt_out_ready) begin
        checks++; if (nout >= beats.size() || pt_out_data !== beats[nout]) begin failures++;
          $display("FAIL pt_data beat %0d got %0h", nout, pt_out_data); end
        else begin
          checks++; if (n - acc_cyc[nout] != 3) begin failures++;
            $display("FAIL pt_latency beat %0d got %0d edges want 2", nout,
                     n - acc_cyc[nout] - 1); end
        end
        nout++;
      end
      acc = pt_in_valid && pt_in_ready;
      if (acc) begin
        beats.push_back(pt_in_data);
        acc_cyc.push_back(n);
      end
      @(posedge clk);
      #1;
      if (acc) for (int i = 0; i < int'(PL); i++) pt_in_data[i*SW +: SW] = SW'($urandom);
      pt_in_valid = beats.size() < 16;
    end
    checks++; if (nout != 16) begin failures++;
      $display("FAIL pt_count got %0d want 16", nout); end
  endtask

`ifdef DAC_GEARBOX_TESTPAT_EN
  task automatic test_testpat();
    apply_reset(0, 1'b0);
    @(posedge clk);
    #1;
    test_mode = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 9500 && got_q.size() < 16400; c++) drive_cycle(0, 100);
    checks++; if (got_q.size() < 16400) begin failures++;
      $display("FAIL tp_count got %0d want >=16400", got_q.size()); end
    check_ramp("tp_ramp", 0);
    checks++; if (got_q.size() > 16384 && got_q[16384] != 0) begin failures++;
      $display("FAIL tp_wrap got %0d want 0", got_q[16384]); end
    test_mode = 1'b0;
  endtask
`endif

  initial begin
    rst          = 1'b1;
    in_data      = '0;
    in_valid     = 1'b0;
    out_ready    = 1'b0;
    pt_in_data   = '0;
    pt_in_valid  = 1'b0;
    pt_out_ready = 1'b0;
`ifdef DAC_GEARBOX_TESTPAT_EN
    test_mode    = 1'b0;
`endif
    viol = 0;
    mon_clear();
    test_reset();
    test_stream();
    test_backpressure();
    test_underrun();
    test_reset_mid();
    test_random();
    test_passthrough();
`ifdef DAC_GEARBOX_TESTPAT_EN
    test_testpat();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "timeout");
  end

endmodule
